// File: rtl/mmio_device_arbiter_pkg.sv
// Shared types and constants for the MMIO device arbiter: request/response
// records exchanged with the device, arbiter states and timeout defaults.
package mmio_device_arbiter_pkg;

    localparam int XLEN    = 32;
    localparam int ID_W    = 4;
    localparam int PADDR_W = 32;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;
    localparam logic [XLEN-1:0] DEV_TIMEOUT_DATA = '1;

    typedef struct packed {
        logic               valid;
        logic [ID_W-1:0]    id;
        logic [PADDR_W-1:0] paddr;
        logic               is_write;
        logic [XLEN-1:0]    data;
    } device_req_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] data;
    } device_res_t;

    typedef enum logic [0:0] {
        ARB_IDLE     = 1'b0,
        ARB_WAIT_RES = 1'b1
    } arb_state_t;

    // Successor of a requester index in round-robin order.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 32'sd1) % n;
    endfunction

endpackage

// File: rtl/mmio_device_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr,
// wrapping around; reports a one-hot grant, its index and whether any won.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int OW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [OW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [OW-1:0] grant_idx,
    output logic          any_grant
);

    logic [OW-1:0] idx_s;

    // Priority scan starting at rr_ptr; the first hit locks out the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx_s     = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = OW'((int'(rr_ptr) + i) % N);
            if (!any_grant && valid[idx_s]) begin
                grant[idx_s] = 1'b1;
                grant_idx    = idx_s;
                any_grant    = 1'b1;
            end else begin
                any_grant = any_grant;
            end
        end
    end

endmodule

// File: rtl/mmio_device_arbiter.sv
// Shares one MMIO device among NUM_REQ requesters: round-robin grants, one
// outstanding read with response routing, stray-response and timeout recovery.
module mmio_device_arbiter
    import mmio_device_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clock,
    input  logic                 reset,
    input  device_req_t          req_in [NUM_REQ],
    output logic [NUM_REQ-1:0]   req_ready_out,
    output device_res_t          res_out [NUM_REQ],
    output device_req_t          dev_req_out,
    input  device_res_t          dev_res_in,
    output logic                 timeout_err_out,
    output logic                 id_err_out
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t        state_r, state_n;
    logic [OW-1:0]     rr_ptr_r, rr_ptr_n;
    logic [OW-1:0]     owner_r, owner_n;
    logic [ID_W-1:0]   saved_id_r, saved_id_n;
    logic [CW-1:0]     count_r, count_n;
    device_req_t       dev_req_r, dev_req_n;
    device_res_t       res_r [NUM_REQ];
    device_res_t       res_n [NUM_REQ];
    logic              timeout_err_r, timeout_err_n;
    logic              id_err_r, id_err_n;

    logic [NUM_REQ-1:0] valid_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [OW-1:0]      grant_idx_s;
    logic               any_grant_s;
    logic [NUM_REQ-1:0] ready_s;

    // Gather the per-requester valid bits for the picker.
    always_comb begin
        valid_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            valid_s[i] = req_in[i].valid;
        end
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .OW (OW)
    ) u_rr_arbiter (
        .valid     (valid_s),
        .rr_ptr    (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_grant (any_grant_s)
    );

    // Next-state, grant and registered-output computation.
    always_comb begin
        state_n       = state_r;
        rr_ptr_n      = rr_ptr_r;
        owner_n       = owner_r;
        saved_id_n    = saved_id_r;
        count_n       = count_r;
        dev_req_n     = '0;
        timeout_err_n = 1'b0;
        id_err_n      = 1'b0;
        ready_s       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            res_n[i] = '0;
        end

        case (state_r)
            ARB_IDLE: begin
                if (any_grant_s) begin
                    ready_s   = grant_s;
                    dev_req_n = req_in[grant_idx_s];
                    rr_ptr_n  = OW'(wrap_inc(int'(grant_idx_s), NUM_REQ));
                    if (!req_in[grant_idx_s].is_write) begin
                        state_n    = ARB_WAIT_RES;
                        owner_n    = grant_idx_s;
                        saved_id_n = req_in[grant_idx_s].id;
                        count_n    = '0;
                    end else begin
                        state_n = ARB_IDLE;
                    end
                end else begin
                    ready_s = '0;
                end
                // Nothing is outstanding, so any response here is a stray.
                id_err_n = dev_res_in.valid;
            end

            ARB_WAIT_RES: begin
                count_n = count_r + CW'(1);
                // A matching response beats a timeout landing in the same cycle.
                if (dev_res_in.valid && (dev_res_in.id == saved_id_r)) begin
                    res_n[owner_r] = '{valid: 1'b1, id: saved_id_r, data: dev_res_in.data};
                    state_n        = ARB_IDLE;
                end else if (count_r == CW'(TIMEOUT_CYCLES - 1)) begin
                    res_n[owner_r] = '{valid: 1'b1, id: saved_id_r, data: DEV_TIMEOUT_DATA};
                    timeout_err_n  = 1'b1;
                    state_n        = ARB_IDLE;
                end else begin
                    state_n = ARB_WAIT_RES;
                end
                if (dev_res_in.valid && (dev_res_in.id != saved_id_r)) begin
                    id_err_n = 1'b1;
                end else begin
                    id_err_n = 1'b0;
                end
            end

            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ARB_IDLE;
            rr_ptr_r      <= '0;
            owner_r       <= '0;
            saved_id_r    <= '0;
            count_r       <= '0;
            dev_req_r     <= '0;
            timeout_err_r <= 1'b0;
            id_err_r      <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                res_r[i] <= '0;
            end
        end else begin
            state_r       <= state_n;
            rr_ptr_r      <= rr_ptr_n;
            owner_r       <= owner_n;
            saved_id_r    <= saved_id_n;
            count_r       <= count_n;
            dev_req_r     <= dev_req_n;
            timeout_err_r <= timeout_err_n;
            id_err_r      <= id_err_n;
            for (int i = 0; i < NUM_REQ; i++) begin
                res_r[i] <= res_n[i];
            end
        end
    end

    // The grant must be combinational to complete the handshake in-cycle.
    assign req_ready_out   = reset ? '0 : ready_s;
    assign res_out         = res_r;
    assign dev_req_out     = dev_req_r;
    assign timeout_err_out = timeout_err_r;
    assign id_err_out      = id_err_r;

endmodule

// File: tb/tb_mmio_device_arbiter.sv
// Directed bench for mmio_device_arbiter (2 requesters, 8-cycle timeout):
// reset, single read, contention, fairness, read blocking, timeout, stray/reset.
module tb_mmio_device_arbiter;
    import mmio_device_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    device_req_t req_in [2];
    logic [1:0]  req_ready_out;
    device_res_t res_out [2];
    device_req_t dev_req_out;
    device_res_t dev_res_in;
    logic        timeout_err_out;
    logic        id_err_out;

    int tests_run;
    int tests_failed;

    mmio_device_arbiter #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_in          (req_in),
        .req_ready_out   (req_ready_out),
        .res_out         (res_out),
        .dev_req_out     (dev_req_out),
        .dev_res_in      (dev_res_in),
        .timeout_err_out (timeout_err_out),
        .id_err_out      (id_err_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic device_req_t mk_req(input logic v, input logic [3:0] id,
                                           input logic [31:0] a, input logic w,
                                           input logic [31:0] d);
        device_req_t r;
        r = '{valid: v, id: id, paddr: a, is_write: w, data: d};
        return r;
    endfunction

    function automatic device_res_t mk_res(input logic v, input logic [3:0] id,
                                           input logic [31:0] d);
        device_res_t r;
        r = '{valid: v, id: id, data: d};
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        device_req_t zreq;
        device_res_t zres;
        zreq = '0;
        zres = '0;
        reset = 1'b1;
        req_in[0] = mk_req(1'b1, 4'd1, 32'h1000_0000, 1'b1, 32'h0);
        req_in[1] = '0;
        dev_res_in = '0;
        #3;
        tests_run++;
        if (req_ready_out !== 2'b00) begin
            tests_failed++; $display("FAIL reset_ready got %b expected 00", req_ready_out);
        end
        tests_run++;
        if (dev_req_out !== zreq || res_out[0] !== zres || res_out[1] !== zres) begin
            tests_failed++; $display("FAIL reset_outputs got req %h res0 %h res1 %h expected 0", dev_req_out, res_out[0], res_out[1]);
        end
        tests_run++;
        if (timeout_err_out !== 1'b0 || id_err_out !== 1'b0) begin
            tests_failed++; $display("FAIL reset_errs got %b%b expected 00", timeout_err_out, id_err_out);
        end
        req_in[0] = '0;
        apply_reset();
    endtask

    task automatic test_single_read();
        device_req_t rq;
        rq = mk_req(1'b1, 4'd3, 32'h1000_0005, 1'b0, 32'h0);
        next_cycle();
        req_in[0] = rq;
        #3;
        tests_run++;
        if (req_ready_out !== 2'b01) begin
            tests_failed++; $display("FAIL single_ready got %b expected 01", req_ready_out);
        end
        next_cycle();
        req_in[0] = '0;
        #3;
        tests_run++;
        if (dev_req_out !== rq) begin
            tests_failed++; $display("FAIL single_dev_req got %h expected %h", dev_req_out, rq);
        end
        next_cycle();
        dev_res_in = mk_res(1'b1, 4'd3, 32'h60);
        #3;
        tests_run++;
        if (dev_req_out.valid !== 1'b0 || req_ready_out !== 2'b00) begin
            tests_failed++; $display("FAIL single_wait got valid %b ready %b expected 0 00", dev_req_out.valid, req_ready_out);
        end
        next_cycle();
        dev_res_in = '0;
        #3;
        tests_run++;
        if (res_out[0] !== mk_res(1'b1, 4'd3, 32'h60) || res_out[1] !== mk_res(1'b0, 4'd0, 32'h0)) begin
            tests_failed++; $display("FAIL single_res got %h / %h expected %h / 0", res_out[0], res_out[1], mk_res(1'b1, 4'd3, 32'h60));
        end
        tests_run++;
        if (id_err_out !== 1'b0 || timeout_err_out !== 1'b0) begin
            tests_failed++; $display("FAIL single_errs got %b%b expected 00", timeout_err_out, id_err_out);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        req_in[0] = mk_req(1'b1, 4'd0, 32'h1000_0000, 1'b1, 32'h41);
        req_in[1] = mk_req(1'b1, 4'd0, 32'h1000_0000, 1'b1, 32'h42);
        #3;
        tests_run++;
        if (req_ready_out !== 2'b01) begin
            tests_failed++; $display("FAIL cont_first got %b expected 01", req_ready_out);
        end
        next_cycle();
        req_in[0] = '0;
        #3;
        tests_run++;
        if (req_ready_out !== 2'b10) begin
            tests_failed++; $display("FAIL cont_second got %b expected 10", req_ready_out);
        end
        tests_run++;
        if (dev_req_out.valid !== 1'b1 || dev_req_out.data !== 32'h41 || dev_req_out.is_write !== 1'b1) begin
            tests_failed++; $display("FAIL cont_dev_a got %h expected data 41 write", dev_req_out);
        end
        next_cycle();
        req_in[1] = '0;
        #3;
        tests_run++;
        if (dev_req_out.valid !== 1'b1 || dev_req_out.data !== 32'h42) begin
            tests_failed++; $display("FAIL cont_dev_b got %h expected data 42", dev_req_out);
        end
        next_cycle();
        req_in[0] = mk_req(1'b1, 4'd0, 32'h1000_0000, 1'b1, 32'h43);
        req_in[1] = mk_req(1'b1, 4'd0, 32'h1000_0000, 1'b1, 32'h44);
        #3;
        tests_run++;
        if (req_ready_out !== 2'b01) begin
            tests_failed++; $display("FAIL cont_ptr_wrap got %b expected 01", req_ready_out);
        end
        next_cycle();
        req_in[0] = '0;
        req_in[1] = '0;
    endtask

    task automatic test_fairness();
        logic [1:0] exp;
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            req_in[0] = mk_req(1'b1, 4'd0, 32'h1000_0000, 1'b1, 32'h10);
            req_in[1] = (c >= 5) ? mk_req(1'b1, 4'd0, 32'h1000_0000, 1'b1, 32'h20) : '0;
            exp = (c < 5) ? 2'b01 : (((c - 5) % 2 == 0) ? 2'b10 : 2'b01);
            #3;
            tests_run++;
            if (req_ready_out !== exp) begin
                tests_failed++; $display("FAIL fair_cycle%0d got %b expected %b", c, req_ready_out, exp);
            end
            next_cycle();
        end
        req_in[0] = '0;
        req_in[1] = '0;
    endtask

    task automatic test_read_blocking();
        req_in[1] = mk_req(1'b1, 4'd5, 32'h1000_0004, 1'b0, 32'h0);
        #3;
        tests_run++;
        if (req_ready_out !== 2'b10) begin
            tests_failed++; $display("FAIL block_grant_read got %b expected 10", req_ready_out);
        end
        next_cycle();
        req_in[1] = '0;
        req_in[0] = mk_req(1'b1, 4'd1, 32'h1000_0000, 1'b1, 32'h55);
        #3;
        tests_run++;
        if (req_ready_out !== 2'b00) begin
            tests_failed++; $display("FAIL block_wait1 got %b expected 00", req_ready_out);
        end
        tests_run++;
        if (dev_req_out.valid !== 1'b1 || dev_req_out.is_write !== 1'b0 || dev_req_out.id !== 4'd5) begin
            tests_failed++; $display("FAIL block_dev_read got %h expected read id 5", dev_req_out);
        end
        next_cycle();
        dev_res_in = mk_res(1'b1, 4'd5, 32'h1234);
        #3;
        tests_run++;
        if (req_ready_out !== 2'b00) begin
            tests_failed++; $display("FAIL block_wait2 got %b expected 00", req_ready_out);
        end
        next_cycle();
        dev_res_in = '0;
        #3;
        tests_run++;
        if (res_out[1] !== mk_res(1'b1, 4'd5, 32'h1234) || res_out[0].valid !== 1'b0) begin
            tests_failed++; $display("FAIL block_res got %h / %h expected %h / 0", res_out[1], res_out[0], mk_res(1'b1, 4'd5, 32'h1234));
        end
        tests_run++;
        if (req_ready_out !== 2'b01) begin
            tests_failed++; $display("FAIL block_resume got %b expected 01", req_ready_out);
        end
        next_cycle();
        req_in[0] = '0;
        #3;
        tests_run++;
        if (dev_req_out.valid !== 1'b1 || dev_req_out.data !== 32'h55 || dev_req_out.is_write !== 1'b1) begin
            tests_failed++; $display("FAIL block_dev_write got %h expected write 55", dev_req_out);
        end
    endtask

    task automatic test_timeout();
        next_cycle();
        req_in[0] = mk_req(1'b1, 4'd7, 32'h1000_0008, 1'b0, 32'h0);
        #3;
        tests_run++;
        if (req_ready_out !== 2'b01) begin
            tests_failed++; $display("FAIL to_grant got %b expected 01", req_ready_out);
        end
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            req_in[0] = '0;
            dev_res_in = (c == 2) ? mk_res(1'b1, 4'd2, 32'hdead) : mk_res(1'b0, 4'd0, 32'h0);
            req_in[1] = (c == 9) ? mk_req(1'b1, 4'd0, 32'h1000_0000, 1'b1, 32'h77) : '0;
            #3;
            tests_run++;
            if (id_err_out !== (c == 3)) begin
                tests_failed++; $display("FAIL to_id_err_c%0d got %b expected %b", c, id_err_out, (c == 3));
            end
            if (c == 9) begin
                tests_run++;
                if (res_out[0] !== mk_res(1'b1, 4'd7, 32'hffff_ffff) || timeout_err_out !== 1'b1) begin
                    tests_failed++; $display("FAIL to_fire got %h err %b expected %h err 1", res_out[0], timeout_err_out, mk_res(1'b1, 4'd7, 32'hffff_ffff));
                end
                tests_run++;
                if (req_ready_out !== 2'b10) begin
                    tests_failed++; $display("FAIL to_idle got %b expected 10", req_ready_out);
                end
            end else begin
                tests_run++;
                if (res_out[0].valid !== 1'b0 || timeout_err_out !== 1'b0) begin
                    tests_failed++; $display("FAIL to_quiet_c%0d got valid %b err %b expected 0 0", c, res_out[0].valid, timeout_err_out);
                end
            end
        end
        req_in[1] = '0;
    endtask

    task automatic test_stray_and_reset();
        device_req_t zreq;
        zreq = '0;
        next_cycle();
        dev_res_in = mk_res(1'b1, 4'd2, 32'h99);
        next_cycle();
        dev_res_in = '0;
        #3;
        tests_run++;
        if (id_err_out !== 1'b1 || res_out[0].valid !== 1'b0 || res_out[1].valid !== 1'b0) begin
            tests_failed++; $display("FAIL stray got id_err %b res %b%b expected 1 00", id_err_out, res_out[1].valid, res_out[0].valid);
        end
        next_cycle();
        req_in[1] = mk_req(1'b1, 4'd9, 32'h1000_0000, 1'b0, 32'h0);
        #3;
        tests_run++;
        if (req_ready_out !== 2'b10) begin
            tests_failed++; $display("FAIL rst_grant got %b expected 10", req_ready_out);
        end
        next_cycle();
        req_in[1] = '0;
        req_in[0] = mk_req(1'b1, 4'd1, 32'h1000_0000, 1'b1, 32'h5);
        #3;
        tests_run++;
        if (dev_req_out.valid !== 1'b1) begin
            tests_failed++; $display("FAIL rst_dev_req got %b expected 1", dev_req_out.valid);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (dev_req_out !== zreq || req_ready_out !== 2'b00 || res_out[0].valid !== 1'b0 || res_out[1].valid !== 1'b0) begin
            tests_failed++; $display("FAIL rst_async got req %h ready %b expected 0 00", dev_req_out, req_ready_out);
        end
        next_cycle();
        req_in[0] = '0;
        reset = 1'b0;
        dev_res_in = mk_res(1'b1, 4'd9, 32'hbeef);
        next_cycle();
        dev_res_in = '0;
        #3;
        tests_run++;
        if (id_err_out !== 1'b1 || res_out[1].valid !== 1'b0) begin
            tests_failed++; $display("FAIL rst_late got id_err %b res1 %b expected 1 0", id_err_out, res_out[1].valid);
        end
        next_cycle();
        #3;
        tests_run++;
        if (id_err_out !== 1'b0 || res_out[1].valid !== 1'b0 || timeout_err_out !== 1'b0) begin
            tests_failed++; $display("FAIL rst_quiet got id_err %b res1 %b to %b expected 0 0 0", id_err_out, res_out[1].valid, timeout_err_out);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_single_read();
        test_contention();
        test_fairness();
        test_read_blocking();
        test_timeout();
        test_stray_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
